// File: rtl/zbt_pkg.sv
// Shared definitions for the ZBT point reader and writer.
//   Word layout: {18'b0, x[9:0], y_field[7:0]}, where y_field = y/4.
//   Contents: bus widths, field widths and offsets, the reader FSM state
//   encoding, and the packed point entry that the reader FIFO stores.
package zbt_pkg;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 36;
  localparam int X_W    = 10;
  localparam int Y_W    = 8;
  localparam int X_LSB  = 8;
  localparam int Y_LSB  = 0;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic           last;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pt_entry_t;
endpackage

// File: rtl/zbt_point_reader_fifo.sv
// point_fifo: synchronous show-ahead FIFO used for the reader's point entries.
//   Ports: clk, rst_n (async low); push/wdata write one entry; pop consumes
//   the head entry. rdata always shows the head entry. valid means the FIFO
//   is not empty. count is the current occupancy.
//   A push and a pop in the same cycle leave the occupancy unchanged.
//   The caller must not push while the FIFO is full unless it also pops.
module point_fifo #(
  parameter  int W     = 19,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic [AW:0]  count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign count = wptr - rptr;
  assign valid = (count != '0);
endmodule

// File: rtl/zbt_point_reader.sv
// zbt_point_reader: reads a run of packed point words from ZBT SRAM and
// streams them out as (x, y) points using valid/ready handshakes.
//   Run control: start, base_addr and count start a run. busy is high while
//   a run is in progress. done pulses once when the run ends.
//   Memory side: mem_addr and mem_we (mem_we is always 0). mem_rdata is valid
//   READ_LAT cycles after the address is presented.
//   Point stream: pt_valid, pt_ready, pt_x, pt_y and pt_last. pt_last marks
//   the final point of the run.
//   Optional: defining ZBT_FORMAT_CHECK_EN adds the sticky fmt_err output.
//   fmt_err is set when a returned word has nonzero upper bits [35:18].
// Read latency is hidden by issuing reads only while a FIFO slot is reserved
// for each one. A slot counts as used from the cycle a read is issued until
// its point is consumed.
module zbt_point_reader #(
  parameter int ADDR_W     = zbt_pkg::ADDR_W,
  parameter int DATA_W     = zbt_pkg::DATA_W,
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       count,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    pt_valid,
  input  logic                    pt_ready,
  output logic [zbt_pkg::X_W-1:0] pt_x,
  output logic [zbt_pkg::Y_W-1:0] pt_y,
  output logic                    pt_last
`ifdef ZBT_FORMAT_CHECK_EN
  , output logic                  fmt_err
`endif
);
  import zbt_pkg::*;

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW  = $clog2(FIFO_DEPTH + READ_LAT + 2) + 1;

  state_t            state, state_nxt;
  logic [READ_LAT:0] vld_pipe, last_pipe;
  logic [ADDR_W-1:0] base_r, cnt_r, issued;
  logic [FCW-1:0]    fifo_cnt;
  logic [CW-1:0]     in_flight, used;
  logic              credit_ok, issue_en, issue, issue_last;
  logic              start_go, start_zero, push, pop, fifo_valid, run_end;
  pt_entry_t         wr_ent, rd_ent;

  assign start_go   = start && (state == IDLE) && (count != '0);
  assign start_zero = start && (state == IDLE) && (count == '0);

  // Count the stages of the READ_LAT+1 stage valid pipe that hold a read.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= READ_LAT; i++) in_flight = in_flight + CW'(vld_pipe[i]);
  end

  // A pop in this cycle frees its slot at the same edge as the new issue.
  // This allows one point per clock in steady state.
  assign used       = in_flight + CW'(fifo_cnt);
  assign credit_ok  = used < (CW'(FIFO_DEPTH) + CW'(pop));
  assign issue      = issue_en && credit_ok;
  assign issue_last = issue && (issued == cnt_r - ADDR_W'(1));

  // The last entry leaving the FIFO means both the pipe and the FIFO are
  // empty from the next cycle. done and the drop of busy line up there.
  assign run_end = pop && rd_ent.last;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = (count == ADDR_W'(1)) ? DRAIN : ISSUE;
      ISSUE:   if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (run_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (state != IDLE);
    issue_en = (state == ISSUE);
  end

  // Word 0 is issued directly off the start pulse, which saves a cycle of
  // latency. Further words are issued from ISSUE as credits allow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      base_r    <= '0;
      cnt_r     <= '0;
      issued    <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      done      <= 1'b0;
    end else begin
      done      <= run_end | start_zero;
      vld_pipe  <= {vld_pipe[READ_LAT-1:0], 1'b0};
      last_pipe <= {last_pipe[READ_LAT-1:0], 1'b0};
      if (start_go) begin
        base_r       <= base_addr;
        cnt_r        <= count;
        mem_addr     <= base_addr;
        issued       <= ADDR_W'(1);
        vld_pipe[0]  <= 1'b1;
        last_pipe[0] <= (count == ADDR_W'(1));
      end else if (issue) begin
        mem_addr     <= base_r + issued;
        issued       <= issued + ADDR_W'(1);
        vld_pipe[0]  <= 1'b1;
        last_pipe[0] <= issue_last;
      end
    end
  end

  assign mem_we = 1'b0;

  // Stage READ_LAT of the pipe lines up with valid mem_rdata.
  assign push = vld_pipe[READ_LAT];
  always_comb begin
    wr_ent = '{last: last_pipe[READ_LAT],
               x:    mem_rdata[X_LSB +: X_W],
               y:    mem_rdata[Y_LSB +: Y_W]};
  end

  point_fifo #(
    .W     ($bits(pt_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_ent),
    .pop   (pop),
    .rdata (rd_ent),
    .valid (fifo_valid),
    .count (fifo_cnt)
  );

  assign pop      = fifo_valid && pt_ready;
  assign pt_valid = fifo_valid;
  assign pt_x     = rd_ent.x;
  assign pt_y     = rd_ent.y;
  assign pt_last  = fifo_valid && rd_ent.last;

`ifdef ZBT_FORMAT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      fmt_err <= 1'b0;
    else if (start_go || start_zero) fmt_err <= 1'b0;
    else if (push && (|mem_rdata[DATA_W-1:X_LSB+X_W])) fmt_err <= 1'b1;
  end
`else
  logic unused_hi;
  assign unused_hi = ^mem_rdata[DATA_W-1:X_LSB+X_W];
`endif
endmodule

// File: tb/tb_zbt_point_reader.sv
module tb_zbt_point_reader;
  logic        clk = 1'b0;
  logic        rst_n, start, busy, done, mem_we, pt_valid, pt_ready, pt_last;
  logic [18:0] base_addr, count, mem_addr;
  logic [35:0] mem_rdata, r1;
  logic [9:0]  pt_x;
  logic [7:0]  pt_y;
`ifdef ZBT_FORMAT_CHECK_EN
  logic        fmt_err;
`endif

  zbt_point_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_last(pt_last)
`ifdef ZBT_FORMAT_CHECK_EN
    , .fmt_err(fmt_err)
`endif
  );

  always #5 clk = ~clk;

  // ZBT model: data for the address presented in cycle t is valid in cycle t+2
  logic [35:0] mem [bit [18:0]];
  always @(posedge clk) begin
    r1        <= mem.exists(mem_addr) ? mem[mem_addr] : 36'h0;
    mem_rdata <= r1;
  end

  int we_bad = 0;
  always @(negedge clk) if (mem_we !== 1'b0) we_bad <= we_bad + 1;

  int checks = 0, errors = 0, viol = 0;
  int ex_x [4], ex_y [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rmode 0: pt_ready held high; rmode 1: pt_ready high 1 cycle in 3.
  // abort_after > 0: stop right after that many handshakes, no end checks.
  task automatic run(input logic [18:0] b, input logic [18:0] c, input int nexp,
                     input int rmode, input int abort_after, input string tag);
    int npts = 0, ndone = 0, done_k = -1, last_k = -1, first_k = -1;
    @(negedge clk);
    base_addr = b; count = c; start = 1'b1; pt_ready = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start    = 1'b0;
      pt_ready = (rmode == 0) || (k % 3 == 0);
      if ($countones(dut.vld_pipe) + int'(dut.fifo_cnt) > 4) viol++;
      if (pt_valid && first_k < 0) first_k = k;
      if (done) begin ndone++; done_k = k; end
      if (pt_valid && pt_ready) begin
        if (npts < nexp) begin
          check({tag, "_x"}, 64'(pt_x), 64'(ex_x[npts]));
          check({tag, "_y"}, 64'(pt_y), 64'(ex_y[npts]));
          check({tag, "_last"}, 64'(pt_last), 64'(npts == nexp - 1));
        end
        npts++;
        last_k = k;
        if (abort_after > 0 && npts == abort_after) break;
      end
      if (done_k > 0 && k >= done_k + 2) break;
    end
    if (abort_after > 0) return;
    check({tag, "_npts"}, 64'(npts), 64'(nexp));
    check({tag, "_ndone"}, 64'(ndone), 64'd1);
    check({tag, "_done_at"}, 64'(done_k), 64'(last_k + 1));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    if (rmode == 0) check({tag, "_first_lat"}, 64'(first_k), 64'd4);
  endtask

  task automatic set_base_exp();
    ex_x[0] = 300; ex_y[0] = 75;
    ex_x[1] = 400; ex_y[1] = 100;
    ex_x[2] = 500; ex_y[2] = 125;
    ex_x[3] = 600; ex_y[3] = 150;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_valid"}, 64'(pt_valid), 64'd0);
    check({tag, "_xyl"}, 64'({pt_x, pt_y, pt_last}), 64'd0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; start = 1'b0; pt_ready = 1'b0; base_addr = '0; count = '0;
    mem[19'h0] = 36'h12C4B; mem[19'h1] = 36'h19064;
    mem[19'h2] = 36'h1F47D; mem[19'h3] = 36'h25896;
    mem[19'h7FFFE] = 36'h00A01; mem[19'h7FFFF] = 36'h01402;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    check("reset_we", 64'(mem_we), 64'd0);
`ifdef ZBT_FORMAT_CHECK_EN
    check("reset_fmt", 64'(fmt_err), 64'd0);
`endif
    rst_n = 1'b1;

    // full-rate run
    set_base_exp();
    run(19'h0, 19'd4, 4, 0, 0, "run_rdy");

    // back-pressured run, slot invariant tracked throughout
    run(19'h0, 19'd4, 4, 1, 0, "run_bp");
    check("bp_slots_viol", 64'(viol), 64'd0);

    // count == 0: done next cycle, nothing read, nothing delivered
    @(negedge clk);
    count = '0; base_addr = 19'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (pt_valid || done || busy) bad++;
    end
    check("zero_quiet", 64'(bad), 64'd0);
    check("zero_addr", 64'(mem_addr), 64'h3);

    // address wrap at the top of the space
    ex_x[0] = 10;  ex_y[0] = 1;
    ex_x[1] = 20;  ex_y[1] = 2;
    ex_x[2] = 300; ex_y[2] = 75;
    ex_x[3] = 400; ex_y[3] = 100;
    run(19'h7FFFE, 19'd4, 4, 0, 0, "wrap");
    check("wrap_last_addr", 64'(mem_addr), 64'h1);

    // reset in the middle of a run, then a clean run
    set_base_exp();
    run(19'h0, 19'd4, 4, 0, 2, "abort");
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("abort_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run(19'h0, 19'd4, 4, 0, 0, "after_rst");

`ifdef ZBT_FORMAT_CHECK_EN
    mem[19'h1] = 36'h800019064;
    run(19'h0, 19'd4, 4, 0, 0, "fmt_bad");
    check("fmt_set", 64'(fmt_err), 64'd1);
    mem[19'h1] = 36'h19064;
    run(19'h0, 19'd4, 4, 0, 0, "fmt_ok");
    check("fmt_cleared", 64'(fmt_err), 64'd0);
`endif

    check("mem_we_low", 64'(we_bad), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
